// File: rtl/sm4_key_expander_if.sv
// Key-load and round-key read bundle shared by the key source, the SM4 key
// expander and the round datapath that consumes the stored round keys.
interface sm4_key_expander_if #(
  parameter int word_width_p = 32,
  parameter int key_size_p   = 128
);
  logic                    key_v_i;
  logic [key_size_p-1:0]   key_i;
  logic                    key_ready_o;
  logic                    busy_o;
  logic                    keys_valid_o;
  logic [4:0]              rd_addr_i;
  logic                    decrypt_i;
  logic [word_width_p-1:0] rk_o;

  // Key source / round datapath side
  modport master (
    output key_v_i, key_i, rd_addr_i, decrypt_i,
    input  key_ready_o, busy_o, keys_valid_o, rk_o
  );

  // Key expander side
  modport slave (
    input  key_v_i, key_i, rd_addr_i, decrypt_i,
    output key_ready_o, busy_o, keys_valid_o, rk_o
  );
endinterface

// File: rtl/sm4_key_expander.sv
// SM4 key schedule: expands a 128-bit master key into the 32 round keys,
// computing rounds_per_cycle_p chained rounds per clock, and serves them
// from a register file in encryption or reversed (decryption) order.

package sm4_encryptor;
  localparam int word_width_p   = 32;
  localparam int key_size_p     = 128;
  localparam int turn_key_num_p = 32;
endpackage

// SM4 byte substitution, purely combinational table lookup.
module sm4_sbox (
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);
  localparam logic [0:255][7:0] c_table = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  assign o_data = c_table[i_data];
endmodule

module sm4_key_expander #(
  parameter int rounds_per_cycle_p = 1,
  parameter int turn_key_num_p     = sm4_encryptor::turn_key_num_p,
  parameter int word_width_p       = sm4_encryptor::word_width_p,
  parameter int key_size_p         = sm4_encryptor::key_size_p
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  sm4_key_expander_if.slave bus
);
  localparam int c_rpc = rounds_per_cycle_p;
  localparam logic [127:0] c_fk = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  // Reject configurations the datapath cannot represent.
  if (!(c_rpc == 1 || c_rpc == 2 || c_rpc == 4 || c_rpc == 8 ||
        c_rpc == 16 || c_rpc == 32)) begin : g_bad_rpc
    $error("sm4_key_expander: rounds_per_cycle_p=%0d must be 1, 2, 4, 8, 16 or 32",
           rounds_per_cycle_p);
  end
  if (turn_key_num_p != 32) begin : g_bad_num
    $error("sm4_key_expander: turn_key_num_p=%0d must be 32", turn_key_num_p);
  end
  if (word_width_p != 32 || key_size_p != 128) begin : g_bad_width
    $error("sm4_key_expander: word_width_p must be 32 and key_size_p 128");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [4:0]              r_cnt;
  // Sliding window {K(i), K(i+1), K(i+2), K(i+3)}, K(i) in the top word.
  logic [key_size_p-1:0]   r_win;
  logic [word_width_p-1:0] r_store [turn_key_num_p];
  logic [word_width_p-1:0] r_rk;

  logic                    w_accept;
  logic                    w_key_ready;
  logic                    w_busy;
  logic                    w_keys_valid;
  logic [word_width_p-1:0] w_rk [c_rpc];
  logic [key_size_p-1:0]   w_win_last;
  logic [4:0]              w_rd_idx;

  // System parameter CK(i): byte j (MSB first) is ((4i+j)*7) mod 256.
  // The multiply by 7 is done as (n<<3)-n on a 7-bit index.
  function automatic logic [31:0] ck_word(input logic [4:0] i_idx);
    logic [31:0] v_word;
    logic [6:0]  v_n;
    logic [9:0]  v_prod;
    v_word = '0;
    for (int j = 0; j < 4; j++) begin
      v_n    = {i_idx, 2'(j)};
      v_prod = {v_n, 3'b000} - {3'b000, v_n};
      v_word = {v_word[23:0], v_prod[7:0]};
    end
    return v_word;
  endfunction

  // Chain of c_rpc rounds. Stage gi handles round r_cnt+gi and hands the
  // shifted window to the next stage; each stage yields one round key.
  genvar gi, gj;
  for (gi = 0; gi < c_rpc; gi++) begin : g_round
    logic [key_size_p-1:0]   w_win_in;
    logic [key_size_p-1:0]   w_win_out;
    logic [word_width_p-1:0] w_x;
    logic [word_width_p-1:0] w_tau;
    logic [word_width_p-1:0] w_l;
    logic [word_width_p-1:0] w_k_new;

    if (gi == 0) begin : g_src
      assign w_win_in = r_win;
    end else begin : g_src
      assign w_win_in = g_round[gi-1].w_win_out;
    end

    assign w_x = w_win_in[95:64] ^ w_win_in[63:32] ^ w_win_in[31:0] ^
                 ck_word(r_cnt + 5'(gi));

    for (gj = 0; gj < 4; gj++) begin : g_byte
      sm4_sbox u_sbox (
        .i_data (w_x[31-8*gj -: 8]),
        .o_data (w_tau[31-8*gj -: 8])
      );
    end

    // Key-schedule linear transform L'(B) = B ^ (B<<<13) ^ (B<<<23).
    assign w_l       = w_tau ^ {w_tau[18:0], w_tau[31:19]} ^ {w_tau[8:0], w_tau[31:9]};
    assign w_k_new   = w_win_in[127:96] ^ w_l;
    assign w_win_out = {w_win_in[95:0], w_k_new};
    assign w_rk[gi]  = w_k_new;
  end

  assign w_win_last = g_round[c_rpc-1].w_win_out;
  assign w_accept   = bus.key_v_i && w_key_ready;
  assign w_rd_idx   = bus.decrypt_i ? (5'd31 - bus.rd_addr_i) : bus.rd_addr_i;

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and status outputs; leave EXPAND after the final group of rounds.
  always_comb begin
    w_state_next = r_state;
    w_key_ready  = 1'b1;
    w_busy       = 1'b0;
    w_keys_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.key_v_i) w_state_next = EXPAND;
      end
      EXPAND: begin
        w_key_ready = 1'b0;
        w_busy      = 1'b1;
        if (r_cnt == 5'(turn_key_num_p - c_rpc)) w_state_next = READY;
      end
      READY: begin
        w_keys_valid = 1'b1;
        if (bus.key_v_i) w_state_next = EXPAND;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Round counter and K window: whitening on accept, slide while expanding.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt <= '0;
      r_win <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_win <= bus.key_i ^ c_fk;
    end else if (r_state == EXPAND) begin
      r_cnt <= r_cnt + 5'(c_rpc);
      r_win <= w_win_last;
    end
  end

  // Round-key store: entry e is written by chain stage e mod c_rpc in the
  // cycle whose counter equals the start of its group, so no write mux.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int e = 0; e < turn_key_num_p; e++) r_store[e] <= '0;
    end else if (r_state == EXPAND) begin
      for (int e = 0; e < turn_key_num_p; e++) begin
        if (r_cnt == 5'(e - (e % c_rpc))) r_store[e] <= w_rk[e % c_rpc];
      end
    end
  end

  // Registered read port, ungated; reversed index for decryption order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rk <= '0;
    end else begin
      r_rk <= r_store[w_rd_idx];
    end
  end

  assign bus.key_ready_o  = w_key_ready;
  assign bus.busy_o       = w_busy;
  assign bus.keys_valid_o = w_keys_valid;
  assign bus.rk_o         = r_rk;
endmodule

// File: doc/sm4_key_expander.md
Name: sm4_key_expander

Overview:
- Parametrised SM4 key-schedule engine. Accepts a 128-bit master key and iteratively derives the 32 round keys (rk0..rk31), computing a configurable number of rounds per clock.
- Stores the round keys in an internal register file. A read port serves them in encryption order or, by mode bit, in reversed (decryption) order.
- Sits between the key-load interface and the SM4 round datapath. Replaces a fixed one-round-per-cycle schedule with a throughput/area-tunable one.
- Widths come from package sm4_encryptor: word_width_p, key_size_p, turn_key_num_p.

Parameters:
- rounds_per_cycle_p, 1, rounds computed per clock. Legal values are 1, 2, 4, 8, 16 and 32. Any other value triggers an elaboration-time $error.
- turn_key_num_p, sm4_encryptor::turn_key_num_p (32), number of round keys. Fixed at 32; any other value triggers an elaboration $error.
- word_width_p, sm4_encryptor::word_width_p (32), round-key width.
- key_size_p, sm4_encryptor::key_size_p (128), master-key width.

Ports:
- clk_i  in  1  Single clock. All state on the rising edge.
- reset_n_i  in  1  Asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronised externally.
- key_v_i  in  1  Master key valid.
- key_i  in  key_size_p  Master key. MK0 = key_i[127:96], MK3 = key_i[31:0].
- key_ready_o  out  1  Block can accept a key.
- busy_o  out  1  Expansion in progress.
- keys_valid_o  out  1  All 32 round keys are stored and consistent with the last accepted key.
- rd_addr_i  in  5  Round-key read index, 0..31.
- decrypt_i  in  1  0: return rk[rd_addr_i]. 1: return rk[31-rd_addr_i].
- rk_o  out  word_width_p  Registered read data.

Behaviour:
- Every rising clk_i edge sees one of three FSM states: IDLE, EXPAND, READY.
- Reset (reset_n_i=0, asynchronous):
  - state=IDLE; round counter=0.
  - All 32 stored keys=0; K working registers=0.
  - rk_o=0; key_ready_o=1; busy_o=0; keys_valid_o=0.
- Outputs by state:
  - key_ready_o = (state != EXPAND).
  - busy_o = (state == EXPAND).
  - keys_valid_o = (state == READY).
- Key acceptance: a key is taken when key_v_i && key_ready_o. On that edge:
  - Load K0..K3 = MKi ^ FKi. FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
  - Clear the round counter; go to EXPAND.
- EXPAND, per cycle: compute rounds_per_cycle_p chained rounds i = cnt .. cnt+rounds_per_cycle_p-1.
  - K(i+4) = K(i) ^ T'(K(i+1) ^ K(i+2) ^ K(i+3) ^ CK(i)).
  - T' = L'(tau(x)). tau applies the team sm4_sbox to each of the 4 bytes. L'(B) = B ^ (B<<<13) ^ (B<<<23).
  - CK(i) byte j (j=0 is the MSB) = ((4i+j)*7) mod 256. Generated combinationally, no ROM.
  - rk(i) = K(i+4) is written to store[i]. The sliding window shifts by rounds_per_cycle_p words.
  - The counter advances by rounds_per_cycle_p.
  - Instantiates 4*rounds_per_cycle_p S-boxes.
- Latency: 32/rounds_per_cycle_p cycles from the accept edge to the edge that sets READY. Example: 32 cycles at p=1, 1 cycle at p=32.
- key_v_i during EXPAND is ignored, because ready is low. Nothing is queued.
- A new key accepted in READY:
  - keys_valid_o falls in the next cycle and the block re-expands.
  - The store is overwritten progressively. Contents are undefined until READY.
- Key presented in the same cycle as the last EXPAND round: not accepted. It is accepted on the next cycle, in READY.
- Read port: rk_o <= store[decrypt_i ? 31-rd_addr_i : rd_addr_i] every cycle, with 1-cycle latency.
  - No handshake and no gating by state.
  - Data is guaranteed only while keys_valid_o=1 at both the request and the return cycle.
- Reset mid-EXPAND aborts immediately to the reset state. Partial keys are cleared.

Test Plan:
- Standard vector, p=1: key_i=0123456789ABCDEFFEDCBA9876543210, decrypt_i=0.
  - key_ready_o=0 for exactly 32 cycles.
  - keys_valid_o rises at cycle 32.
  - Reads give rd_addr 0 -> F12186F9, 1 -> 41662B61, 31 -> 9124A012.
- Same key with rounds_per_cycle_p=4 and 32:
  - READY after 8 and 1 cycles respectively.
  - All 32 stored keys are bit-identical to the p=1 run.
- Decrypt order: after the standard expansion, decrypt_i=1.
  - rd_addr 0 -> 9124A012; rd_addr 31 -> F12186F9.
  - rk_o updates one cycle after the address changes.
- Back-to-back keys:
  - key_v_i held high with a second key during EXPAND is ignored until READY.
  - The second key is then accepted; keys_valid_o drops the next cycle and returns after another 32/p cycles.
  - Stored keys match the reference model for the second key.
- Async reset mid-expansion: assert reset_n_i at cycle 10 of EXPAND, between clock edges.
  - Outputs go to reset values without waiting for a clock edge: keys_valid_o=0, busy_o=0, key_ready_o=1, rk_o=0.
  - Re-keying afterwards produces correct keys.
- Illegal parameter rounds_per_cycle_p=3 -> elaboration error.
